dnn_argmax_collector: RTL and testbench

- Sits directly downstream of the DNN output stage.
- Consumes each classification vector of NumClasses signed BitSize scores and scans it sequentially, one score per cycle, to find the winning class.
- Presents class index and score to the result consumer with a valid/ready handshake.
- Counts results per image set and flags the last one, so software/bench can frame a full set.

---
 rtl/dnn_argmax_collector.sv | 132 +++++++++++++
 tb/tb_dnn_argmax_collector.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_argmax_collector.sv
// ============================================================================
// dnn_argmax_collector: sequential signed argmax over one score vector per
// result, with valid/ready output and per-set result counting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dnn_argmax_collector #(
    parameter int BitSize    = 32,
    parameter int NumClasses = 2,
    parameter int NumResults = 4,
    parameter int IdxW       = (NumClasses > 1) ? $clog2(NumClasses) : 1,
    parameter int CntW       = (NumResults > 1) ? $clog2(NumResults) : 1
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  logic                         in_clear,
    input  logic                         in_valid,
    input  logic [NumClasses*BitSize-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IdxW-1:0]              out_class,
    output logic signed [BitSize-1:0]    out_score,
    output logic                         out_last,
    output logic [CntW-1:0]              out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [IdxW-1:0] c_idx_one  = IdxW'(1);
    localparam logic [IdxW-1:0] c_idx_last = IdxW'(NumClasses - 1);
    localparam logic [CntW-1:0] c_cnt_one  = CntW'(1);
    localparam logic [CntW-1:0] c_cnt_last = CntW'(NumResults - 1);

    state_e                     state_q, state_d;
    logic signed [BitSize-1:0]  vec_q [NumClasses];
    logic signed [BitSize-1:0]  best_val_q, best_val_d;
    logic [IdxW-1:0]            best_idx_q, best_idx_d;
    logic [IdxW-1:0]            scan_idx_q, scan_idx_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       w_capture;
    logic signed [BitSize-1:0]  w_in_score [NumClasses];

    generate
        for (genvar k = 0; k < NumClasses; k++) begin : g_unpack
            assign w_in_score[k] = in_data[k*BitSize +: BitSize];
        end
    endgenerate

    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            state_q    <= IDLE;
            best_val_q <= '0;
            best_idx_q <= '0;
            scan_idx_q <= '0;
            cnt_q      <= '0;
            for (int k = 0; k < NumClasses; k++) begin
                vec_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            scan_idx_q <= scan_idx_d;
            cnt_q      <= cnt_d;
            if (w_capture) begin
                for (int k = 0; k < NumClasses; k++) begin
                    vec_q[k] <= w_in_score[k];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        scan_idx_d = scan_idx_q;
        cnt_d      = cnt_q;
        w_capture  = 1'b0;
        // Clear wins over any same-cycle capture or handoff.
        if (in_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        w_capture  = 1'b1;
                        best_val_d = w_in_score[0];
                        best_idx_d = '0;
                        scan_idx_d = c_idx_one;
                        state_d    = (NumClasses == 1) ? HOLD : SCAN;
                    end
                end
                SCAN: begin
                    // Strictly greater only, so ties keep the lower index.
                    if (vec_q[scan_idx_q] > best_val_q) begin
                        best_val_d = vec_q[scan_idx_q];
                        best_idx_d = scan_idx_q;
                    end
                    scan_idx_d = scan_idx_q + c_idx_one;
                    if (scan_idx_q == c_idx_last) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        cnt_d   = (cnt_q == c_cnt_last) ? '0 : cnt_q + c_cnt_one;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !res_n;
    assign out_valid = (state_q == HOLD);
    assign out_class = best_idx_q;
    assign out_score = best_val_q;
    assign out_count = cnt_q;
    assign out_last  = (cnt_q == c_cnt_last);

endmodule

`default_nettype wire

// File: tb/tb_dnn_argmax_collector.sv
// ============================================================================
// tb_dnn_argmax_collector: directed and random stimulus against an argmax model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dnn_argmax_collector;

    localparam int NC = 6;
    localparam int NR = 4;
    localparam int W  = NC * 32;

    logic          clk = 1'b0;
    logic          res_n = 1'b1;
    logic          in_clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    out_class;
    logic [31:0]   out_score;
    logic          out_last;
    logic [1:0]    out_count;

    logic          in_clear2 = 1'b0;
    logic          in_valid2 = 1'b0;
    logic [63:0]   in_data2 = '0;
    logic          in_ready2;
    logic          out_valid2;
    logic          out_ready2 = 1'b1;
    logic          out_class2;
    logic [31:0]   out_score2;
    logic          out_last2;
    logic [1:0]    out_count2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: vector in flight, cycles until valid, winner, set counter.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    int          m_cls  = 0;
    logic [31:0] m_sc   = '0;
    int          m_cnt  = 0;

    always #5 clk = ~clk;

    dnn_argmax_collector #(.BitSize(32), .NumClasses(NC), .NumResults(NR)) u_dut (
        .clk(clk), .res_n(res_n), .in_clear(in_clear), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_class(out_class), .out_score(out_score),
        .out_last(out_last), .out_count(out_count)
    );

    dnn_argmax_collector u_dut2 (
        .clk(clk), .res_n(res_n), .in_clear(in_clear2), .in_valid(in_valid2),
        .in_data(in_data2), .in_ready(in_ready2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_class(out_class2), .out_score(out_score2),
        .out_last(out_last2), .out_count(out_count2)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    function automatic void argmax(input logic [W-1:0] d, output int cls, output logic [31:0] sc);
        cls = 0;
        sc  = d[31:0];
        for (int k = 1; k < NC; k++) begin
            if ($signed(d[k*32 +: 32]) > $signed(sc)) begin
                cls = k;
                sc  = d[k*32 +: 32];
            end
        end
    endfunction

    function automatic logic [W-1:0] pack6(input logic [31:0] a0, a1, a2, a3, a4, a5);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [W-1:0] gen();
        logic [W-1:0] d;
        logic [31:0]  v;
        for (int k = 0; k < NC; k++) begin
            case ($urandom % 6)
                0:       v = 32'h8000_0000;
                1:       v = 32'h7FFF_FFFF;
                2:       v = 32'd7;
                3:       v = 32'hFFFF_FFFF;
                4:       v = 32'd0;
                default: v = $urandom;
            endcase
            d[k*32 +: 32] = v;
        end
        return d;
    endfunction

    // Every-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin
        if (res_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_class", out_class, 0);
            check("rst_out_score", out_score, 0);
            check("rst_out_count", out_count, 0);
            check("rst_out_last", out_last, 0);
            m_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            check("in_ready", in_ready, !m_busy);
            check("out_valid", out_valid, m_busy && m_wait == 0);
            if (m_busy && m_wait == 0) begin
                check("out_class", out_class, m_cls);
                check("out_score", out_score, m_sc);
                check("out_count", out_count, m_cnt);
                check("out_last", out_last, m_cnt == NR - 1);
            end
            if (in_clear) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    argmax(in_data, m_cls, m_sc);
                    m_busy = 1'b1;
                    m_wait = NC - 1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (out_ready) begin
                m_busy = 1'b0;
                m_cnt  = (m_cnt + 1) % NR;
            end
        end
    end

    // One vector; optional clear at scan cycle clr_at, optional stall of hold cycles.
    task automatic send(input logic [W-1:0] d, input int clr_at, input int hold,
                        input int e_cls, input logic [31:0] e_sc, input int e_cnt, input bit e_last);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        check("dir_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= NC; k++) begin
            if (k == clr_at) in_clear = 1'b1;
            @(negedge clk);
            check("dir_valid_timing", out_valid, (k == NC) && (clr_at == 0));
            if (k == NC && clr_at == 0) begin
                check("dir_class", out_class, e_cls);
                check("dir_score", out_score, e_sc);
                check("dir_count", out_count, e_cnt);
                check("dir_last", out_last, e_last);
            end
            @(posedge clk); #1;
            in_clear = 1'b0;
        end
        if (clr_at == 0) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = h[0];
                in_data  = gen();
                @(negedge clk);
                check("dir_hold_ready", in_ready, 0);
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end else begin
            repeat (3) begin
                @(negedge clk);
                check("dir_clr_no_valid", out_valid, 0);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        in_clear = 1'b1;
        @(posedge clk); #1;
        in_clear = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v1, v2, v3, v4, v5;
        int          c;
        logic [31:0] s;
        v1 = pack6(-32'sd10, -32'sd2, 32'd7, 32'd7, -32'sd128, 32'd3);
        v2 = {NC{32'h8000_0000}};
        v3 = pack6(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
        v4 = pack6(32'h7FFF_FFFF, -32'sd1, -32'sd1, -32'sd1, -32'sd1, -32'sd1);
        v5 = '0;

        argmax(v1, c, s);
        check("model_pin_cls_v1", c, 2);
        check("model_pin_sc_v1", s, 7);
        argmax(v2, c, s);
        check("model_pin_cls_min", c, 0);
        check("model_pin_sc_min", s, 32'h8000_0000);

        @(negedge clk);
        check("rst_in_ready2", in_ready2, 0);
        repeat (2) @(posedge clk);
        #1 res_n = 1'b0;

        // Two-class instance: {5, -3} valid two cycles after capture.
        @(posedge clk); #1;
        in_valid2 = 1'b1;
        in_data2  = {-32'sd3, 32'sd5};
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        check("nc2_valid_t1", out_valid2, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nc2_valid_t2", out_valid2, 1);
        check("nc2_class", out_class2, 0);
        check("nc2_score", out_score2, 5);
        check("nc2_count", out_count2, 0);
        check("nc2_last", out_last2, 0);
        @(posedge clk); #1;

        send(v1, 0, 5, 2, 32'd7, 0, 1'b0);
        send(v2, 0, 0, 0, 32'h8000_0000, 1, 1'b0);
        send(v3, 0, 1, 5, 32'd6, 2, 1'b0);
        send(v4, 0, 0, 0, 32'h7FFF_FFFF, 3, 1'b1);
        send(v5, 0, 0, 0, 32'd0, 0, 1'b0);

        pulse_clear();
        send(v3, 0, 0, 5, 32'd6, 0, 1'b0);
        send(v4, 0, 0, 0, 32'h7FFF_FFFF, 1, 1'b0);
        send(v1, 2, 0, 0, 32'd0, 0, 1'b0);
        send(v1, 0, 0, 2, 32'd7, 0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 2) == 0;
            out_ready = ($urandom % 3) != 0;
            in_clear  = ($urandom % 40) == 0;
            in_data   = gen();
        end

        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_clear  = 1'b1;
        @(posedge clk); #1;
        in_clear  = 1'b0;

        // Asynchronous reset while holding a result.
        in_valid = 1'b1;
        in_data  = gen();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (NC - 1) @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        #2 res_n = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_class", out_class, 0);
        check("async_rst_score", out_score, 0);
        check("async_rst_ready", in_ready, 0);
        @(posedge clk); #1;
        res_n = 1'b0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
